adc_acq_sequencer: RTL and testbench
====================================

Name: adc_acq_sequencer

Overview:
Acquisition controller placed in front of the ADC capture block. It latches a capture configuration and drives the ADC's limiter, trigger level, trigger enable and max-sum clear. It then waits for the ADC trigger and gates the ADC AXI-Stream into a fixed number of fixed-length frames, generating its own tlast. Software starts, monitors and aborts captures through this block.

Parameters:
FRAME_W, 16, width of frame-length config and beat counter
SETTLE_CYCLES, 4, cycles spent in CONFIG after max-sum clear before arming (min 1)
DATA_W, 32, stream data width

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
start  in  1  single-cycle start request
abort  in  1  single-cycle abort request
cfg_limiter  in  8  decimation setting for ADC
cfg_trigger_level  in  16  trigger threshold for ADC
cfg_frame_len  in  FRAME_W  beats per frame (0 treated as 1)
cfg_num_frames  in  16  frames per acquisition (0 treated as 1)
cfg_timeout  in  32  WAIT_TRIG timeout in cycles (used only with ACQ_TIMEOUT_EN)
adc_limiter  out  8  shadowed limiter to ADC
adc_trigger_level  out  16  shadowed threshold to ADC
adc_trig_en  out  1  trigger enable/arm to ADC
adc_max_sum_clr  out  1  max-sum clear pulse to ADC
adc_trigger_activated  in  1  ADC trigger status
s_axis_tvalid  in  1  ADC stream valid (no backpressure available)
s_axis_tdata  in  DATA_W  ADC stream data
m_axis_tvalid  out  1  framed output valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  DATA_W  framed output data
m_axis_tlast  out  1  last beat of frame
busy  out  1  acquisition in progress
done  out  1  one-cycle completion pulse
aborted  out  1  sticky: last acquisition aborted
timed_out  out  1  sticky: last acquisition timed out
frames_done  out  16  frames completed in current/last acquisition
drop_count  out  16  saturating count of beats dropped for lack of tready
state_dbg  out  3  current state encoding

Behaviour:
- States and encodings: IDLE=0, CONFIG=1, ARM=2, WAIT_TRIG=3, CAPTURE=4, GAP=5, DONE=6.
- Reset values:
  - state IDLE; all outputs 0.
  - adc_limiter and adc_trigger_level are 0 until the first start.
- IDLE:
  - start=1: latch all cfg_* into shadow registers and clear aborted, timed_out, frames_done and drop_count; next state CONFIG.
  - start while busy=1 is ignored.
- CONFIG:
  - adc_max_sum_clr=1 in the first CONFIG cycle only.
  - Stay SETTLE_CYCLES cycles, then go to ARM.
  - adc_limiter and adc_trigger_level come from the shadow registers and are stable until the next start.
- ARM: one cycle, adc_trig_en=0 (forces ADC trigger logic to re-arm); next state WAIT_TRIG.
- WAIT_TRIG: adc_trig_en=1; adc_trigger_activated=1 moves to CAPTURE on the next cycle.
- CAPTURE: adc_trig_en=1. For each beat with s_axis_tvalid=1:
  - m_axis_tready=1: forward the beat registered, 1-cycle latency (m_axis_tvalid and m_axis_tdata appear next cycle), and increment beat_cnt.
  - m_axis_tready=0: drop the beat; drop_count increments (saturates at 0xFFFF); beat_cnt unchanged.
  - The tready used for the decision is the one sampled in the same cycle as s_axis_tvalid.
  - Beat with beat_cnt == frame_len-1 carries m_axis_tlast=1; beat_cnt wraps to 0 and frames_done increments.
  - After the final frame (frames_done reaches num_frames) go to DONE; otherwise go to GAP.
- GAP: one cycle, adc_trig_en=0, incoming beats ignored (not counted as drops); next state ARM. Each frame therefore needs a new trigger.
- DONE: done=1 for one cycle; next state IDLE.
- busy=1 in every state except IDLE.
- abort (any non-IDLE state):
  - Next state IDLE; aborted=1 (sticky until next start).
  - Any in-flight registered beat is still presented; no further beats; no synthetic tlast, so the partial frame is truncated.
  - abort and start in the same cycle: abort wins, start is ignored.
- m_axis_tvalid never depends combinationally on m_axis_tready.
- areset mid-acquisition: immediate return to reset values next cycle, including outputs to the ADC.

Optional Feature:
ACQ_TIMEOUT_EN
- Defined:
  - A 32-bit counter runs in WAIT_TRIG and clears on entry.
  - Reaching cfg_timeout (shadowed; 0 disables the timeout) sends the block to IDLE with timed_out=1 (sticky until next start).
  - done is not pulsed on timeout.
- Not defined: no counter; WAIT_TRIG waits indefinitely; timed_out tied 0; cfg_timeout unused.

Test Plan:
- Basic capture: frame_len=4, num_frames=2, tready=1, trigger asserted 3 cycles after ARM, ADC data incrementing -> 8 beats out, tlast on beats 4 and 8, frames_done=2, done pulses once, drop_count=0.
- Config sequencing: start with limiter=8, trigger_level=20 -> adc_max_sum_clr high exactly 1 cycle; ARM entered SETTLE_CYCLES=4 cycles later; adc_limiter=8 and adc_trigger_level=20 held although cfg_* change after start.
- Backpressure: frame_len=4, tready low for 2 valid beats mid-frame -> drop_count=2, frame still contains exactly 4 forwarded beats with tlast on the 4th.
- Abort mid-frame after 2 of 4 beats -> IDLE next cycle, aborted=1, no tlast emitted, busy=0; a subsequent start clears aborted.
- Edge config: frame_len=0, num_frames=0 -> behaves as 1x1: a single beat with tlast=1, then done.
- ACQ_TIMEOUT_EN, cfg_timeout=100, trigger never asserted -> IDLE 100 cycles after entering WAIT_TRIG, timed_out=1, done=0.

Source files
------------

// File: rtl/adc_acq_sequencer.sv
// Acquisition sequencer: shadows ADC config, arms the trigger and cuts the ADC stream into fixed frames.
// Define ACQ_TIMEOUT_EN to add a WAIT_TRIG timeout that returns to IDLE with sticky timed_out.
module adc_acq_sequencer #(
  parameter int FRAME_W       = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int DATA_W        = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        cfg_limiter,
  input  logic [15:0]       cfg_trigger_level,
  input  logic [FRAME_W-1:0] cfg_frame_len,
  input  logic [15:0]       cfg_num_frames,
  input  logic [31:0]       cfg_timeout,
  output logic [7:0]        adc_limiter,
  output logic [15:0]       adc_trigger_level,
  output logic              adc_trig_en,
  output logic              adc_max_sum_clr,
  input  logic              adc_trigger_activated,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              timed_out,
  output logic [15:0]       frames_done,
  output logic [15:0]       drop_count,
  output logic [2:0]        state_dbg
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONFIG    = 3'd1,
    ARM       = 3'd2,
    WAIT_TRIG = 3'd3,
    CAPTURE   = 3'd4,
    GAP       = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t               state;
  logic [FRAME_W-1:0]   frame_last;
  logic [FRAME_W-1:0]   beat_cnt;
  logic [15:0]          num_frames_q;
  logic [SETTLE_W-1:0]  settle_cnt;

`ifdef ACQ_TIMEOUT_EN
  logic [31:0] timeout_q;
  logic [31:0] timeout_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout;
  assign timed_out      = 1'b0;
`endif

  assign state_dbg = state;

  // Frame length is stored as its last beat index so zero-length configs collapse to one beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state             <= IDLE;
      frame_last        <= '0;
      beat_cnt          <= '0;
      num_frames_q      <= '0;
      settle_cnt        <= '0;
      adc_limiter       <= '0;
      adc_trigger_level <= '0;
      adc_trig_en       <= 1'b0;
      adc_max_sum_clr   <= 1'b0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tlast      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      aborted           <= 1'b0;
      frames_done       <= '0;
      drop_count        <= '0;
`ifdef ACQ_TIMEOUT_EN
      timeout_q         <= '0;
      timeout_cnt       <= '0;
      timed_out         <= 1'b0;
`endif
    end else begin
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      adc_max_sum_clr <= 1'b0;
      done            <= 1'b0;
      if (abort && state != IDLE) begin
        state       <= IDLE;
        busy        <= 1'b0;
        adc_trig_en <= 1'b0;
        aborted     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              adc_limiter       <= cfg_limiter;
              adc_trigger_level <= cfg_trigger_level;
              frame_last        <= (cfg_frame_len == '0) ? '0 : cfg_frame_len - FRAME_W'(1);
              num_frames_q      <= (cfg_num_frames == 16'd0) ? 16'd1 : cfg_num_frames;
              beat_cnt          <= '0;
              settle_cnt        <= '0;
              aborted           <= 1'b0;
              frames_done       <= '0;
              drop_count        <= '0;
              adc_max_sum_clr   <= 1'b1;
              busy              <= 1'b1;
              state             <= CONFIG;
`ifdef ACQ_TIMEOUT_EN
              timeout_q         <= cfg_timeout;
              timed_out         <= 1'b0;
`endif
            end
          end
          CONFIG: begin
            if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
              state <= ARM;
            end else begin
              settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
          end
          ARM: begin
            adc_trig_en <= 1'b1;
            state       <= WAIT_TRIG;
`ifdef ACQ_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
          end
          WAIT_TRIG: begin
            if (adc_trigger_activated) begin
              state <= CAPTURE;
            end
`ifdef ACQ_TIMEOUT_EN
            else if (timeout_q != 32'd0 && timeout_cnt == timeout_q - 32'd1) begin
              state       <= IDLE;
              busy        <= 1'b0;
              adc_trig_en <= 1'b0;
              timed_out   <= 1'b1;
            end else begin
              timeout_cnt <= timeout_cnt + 32'd1;
            end
`endif
          end
          CAPTURE: begin
            // The ADC cannot be stalled, so a beat without tready is lost and only counted.
            if (s_axis_tvalid) begin
              if (m_axis_tready) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                if (beat_cnt == frame_last) begin
                  m_axis_tlast <= 1'b1;
                  beat_cnt     <= '0;
                  frames_done  <= frames_done + 16'd1;
                  adc_trig_en  <= 1'b0;
                  if (frames_done + 16'd1 == num_frames_q) begin
                    state <= DONE;
                    done  <= 1'b1;
                  end else begin
                    state <= GAP;
                  end
                end else begin
                  beat_cnt <= beat_cnt + FRAME_W'(1);
                end
              end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
              end
            end
          end
          GAP: begin
            state <= ARM;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            busy        <= 1'b0;
            adc_trig_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Self-checking bench for adc_acq_sequencer: directed scenarios plus randomized captures
// checked against a beat-list model built from the stimulus the bench itself drove.
module tb_adc_acq_sequencer;

  typedef struct packed {
    int          cyc;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_limiter = '0;
  logic [15:0] cfg_trigger_level = '0;
  logic [15:0] cfg_frame_len = '0;
  logic [15:0] cfg_num_frames = '0;
  logic [31:0] cfg_timeout = '0;
  logic [7:0]  adc_limiter;
  logic [15:0] adc_trigger_level;
  logic        adc_trig_en;
  logic        adc_max_sum_clr;
  logic        adc_trigger_activated = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        timed_out;
  logic [15:0] frames_done;
  logic [15:0] drop_count;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int clr_cnt = 0;
  beat_t got_mem [0:1023];
  int got_n = 0;
  int got_rd = 0;
  beat_t exp_q [$];
  int seq = 0;

  adc_acq_sequencer dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort),
    .cfg_limiter(cfg_limiter), .cfg_trigger_level(cfg_trigger_level),
    .cfg_frame_len(cfg_frame_len), .cfg_num_frames(cfg_num_frames), .cfg_timeout(cfg_timeout),
    .adc_limiter(adc_limiter), .adc_trigger_level(adc_trigger_level),
    .adc_trig_en(adc_trig_en), .adc_max_sum_clr(adc_max_sum_clr),
    .adc_trigger_activated(adc_trigger_activated),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .aborted(aborted), .timed_out(timed_out),
    .frames_done(frames_done), .drop_count(drop_count), .state_dbg(state_dbg)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Output monitor samples on the falling edge, away from the active edge.
  always @(negedge aclk) begin
    if (m_axis_tvalid === 1'b1 && got_n < 1024) begin
      got_mem[got_n] <= '{cyc: cyc, last: m_axis_tlast, data: m_axis_tdata};
      got_n <= got_n + 1;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (adc_max_sum_clr === 1'b1) clr_cnt <= clr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic [31:0] d, input logic trig);
    s_axis_tvalid = v;
    m_axis_tready = r;
    s_axis_tdata = d;
    adc_trigger_activated = trig;
    step();
  endtask

  task automatic doStart(input int lim, input int lvl, input int len, input int nf, input int tmo);
    cfg_limiter = lim[7:0];
    cfg_trigger_level = lvl[15:0];
    cfg_frame_len = len[15:0];
    cfg_num_frames = nf[15:0];
    cfg_timeout = tmo;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic waitArm(output bit ok);
    int w = 0;
    while (adc_trig_en !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    ok = (adc_trig_en === 1'b1);
    checkOutput("trig_en_armed", adc_trig_en, 1);
  endtask

  // Model: every beat offered with tready while capturing is forwarded one cycle later,
  // and each frame ends after len forwarded beats with tlast on the last.
  task automatic runFrames(input int len_cfg, input int nf_cfg, input int pv, input int pr,
                           input int unsigned low_mask, input int trig_delay, input bit incr,
                           output int drops);
    int len_eff;
    int nf_eff;
    int fwd;
    int guard;
    int offered;
    bit ok;
    logic v;
    logic r;
    logic [31:0] d;
    len_eff = (len_cfg == 0) ? 1 : len_cfg;
    nf_eff = (nf_cfg == 0) ? 1 : nf_cfg;
    drops = 0;
    offered = 0;
    for (int f = 0; f < nf_eff; f++) begin
      waitArm(ok);
      if (!ok) return;
      for (int i = 0; i < trig_delay; i++) applyStimulus(1'b1, 1'b1, 32'hDEAD0000 + i, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
      fwd = 0;
      guard = 0;
      while (fwd < len_eff && guard < 200) begin
        v = ($urandom_range(99) < pv);
        r = ($urandom_range(99) < pr);
        if (v && offered < 32 && low_mask[offered]) r = 1'b0;
        d = incr ? seq : $urandom;
        applyStimulus(v, r, d, 1'b0);
        if (v) begin
          offered++;
          seq++;
          if (r) begin
            exp_q.push_back('{cyc: cyc, last: (fwd == len_eff - 1), data: d});
            fwd++;
          end else begin
            drops++;
          end
        end
        guard++;
      end
      checkOutput("frame_complete", fwd, len_eff);
      if (f < nf_eff - 1) applyStimulus(1'b1, 1'b0, 32'h0BAD0BAD, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic compareBeats(input string tag);
    beat_t e;
    beat_t g;
    checkOutput({tag, "_beat_count"}, got_n - got_rd, exp_q.size());
    while (exp_q.size() > 0 && got_rd < got_n) begin
      e = exp_q.pop_front();
      g = got_mem[got_rd];
      got_rd++;
      checkOutput({tag, "_beat_cycle"}, g.cyc, e.cyc);
      checkOutput({tag, "_beat_last_data"}, {g.last, g.data}, {e.last, e.data});
    end
    got_rd = got_n;
    exp_q.delete();
  endtask

  task automatic finishAcq(input string tag, input int nf_eff, input int drops, input int done_base);
    int w = 0;
    while (busy !== 1'b0 && w < 30) begin
      step();
      w++;
    end
    step();
    checkOutput({tag, "_idle"}, {busy, state_dbg}, 0);
    checkOutput({tag, "_frames_done"}, frames_done, nf_eff);
    checkOutput({tag, "_drop_count"}, drop_count, drops);
    checkOutput({tag, "_done_pulses"}, done_cnt - done_base, 1);
    checkOutput({tag, "_sticky"}, {aborted, timed_out}, 0);
    compareBeats(tag);
  endtask

  initial begin
    int n;
    int drops;
    int done_base;
    int clr_base;
    int c0;
    int len;
    int nf;
    bit ok;

    $display("[TB] reset");
    step();
    step();
    checkOutput("reset_state", state_dbg, 0);
    checkOutput("reset_flags", {busy, done, aborted, timed_out, adc_trig_en, adc_max_sum_clr, m_axis_tvalid, m_axis_tlast}, 0);
    checkOutput("reset_adc_cfg", {adc_limiter, adc_trigger_level}, 0);
    checkOutput("reset_counts", {frames_done, drop_count}, 0);
    areset = 1'b0;
    step();

    $display("[TB] config sequencing and basic capture");
    done_base = done_cnt;
    clr_base = clr_cnt;
    doStart(8, 20, 4, 2, 0);
    checkOutput("config_state", state_dbg, 1);
    checkOutput("config_max_sum_clr", adc_max_sum_clr, 1);
    checkOutput("config_busy", busy, 1);
    cfg_limiter = 8'd99;
    cfg_trigger_level = 16'd777;
    cfg_frame_len = 16'd9;
    cfg_num_frames = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (state_dbg !== 3'd2 && n < 20) begin
      step();
      n++;
    end
    checkOutput("arm_latency", n, 4);
    checkOutput("max_sum_clr_pulses", clr_cnt - clr_base, 1);
    checkOutput("arm_trig_en", adc_trig_en, 0);
    checkOutput("shadow_cfg", {adc_limiter, adc_trigger_level}, {8'd8, 16'd20});
    runFrames(4, 2, 100, 100, 0, 2, 1'b1, drops);
    checkOutput("shadow_cfg_held", {adc_limiter, adc_trigger_level}, {8'd8, 16'd20});
    finishAcq("basic", 2, drops, done_base);

    $display("[TB] backpressure");
    done_base = done_cnt;
    doStart(3, 100, 4, 1, 0);
    runFrames(4, 1, 100, 100, 32'b1100, 1, 1'b1, drops);
    finishAcq("backpressure", 1, drops, done_base);

    $display("[TB] randomized captures");
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(0, 6);
      nf = $urandom_range(0, 3);
      done_base = done_cnt;
      doStart($urandom_range(0, 255), $urandom_range(0, 65535), len, nf, 0);
      runFrames(len, nf, 70, 70, 0, $urandom_range(0, 4), 1'b0, drops);
      finishAcq("random", (nf == 0) ? 1 : nf, drops, done_base);
    end

    $display("[TB] abort mid-frame");
    doStart(1, 2, 4, 1, 0);
    waitArm(ok);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 32'hA0 + i, 1'b0);
      exp_q.push_back('{cyc: cyc, last: 1'b0, data: 32'hA0 + i});
    end
    abort = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'hA5, 1'b0);
    abort = 1'b0;
    checkOutput("abort_state", state_dbg, 0);
    checkOutput("abort_flags", {aborted, busy, adc_trig_en}, 3'b100);
    applyStimulus(1'b1, 1'b1, 32'hA6, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    compareBeats("abort");

    $display("[TB] zero frame_len and num_frames");
    done_base = done_cnt;
    doStart(4, 5, 0, 0, 0);
    checkOutput("restart_clears_aborted", aborted, 0);
    runFrames(0, 0, 100, 100, 0, 0, 1'b1, drops);
    finishAcq("edge", 1, drops, done_base);

    $display("[TB] trigger never arrives");
    done_base = done_cnt;
    doStart(6, 7, 4, 1, 100);
    waitArm(ok);
    c0 = cyc;
`ifdef ACQ_TIMEOUT_EN
    n = 0;
    while (state_dbg !== 3'd0 && n < 300) begin
      step();
      n++;
    end
    checkOutput("timeout_cycles", cyc - c0, 100);
    checkOutput("timeout_flags", {timed_out, busy, aborted}, 3'b100);
    checkOutput("timeout_no_done", done_cnt - done_base, 0);
`else
    repeat (150) step();
    checkOutput("no_timeout_wait", state_dbg, 3);
    checkOutput("no_timeout_flag", timed_out, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("no_timeout_abort", {state_dbg, aborted}, 4'b0001);
`endif

    $display("[TB] reset during capture");
    doStart(8'h5A, 16'h1234, 4, 1, 0);
    waitArm(ok);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h55, 1'b0);
    areset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("midreset_state", state_dbg, 0);
    checkOutput("midreset_flags", {busy, done, aborted, timed_out, adc_trig_en, adc_max_sum_clr, m_axis_tvalid, m_axis_tlast}, 0);
    checkOutput("midreset_adc_cfg", {adc_limiter, adc_trigger_level}, 0);
    checkOutput("midreset_counts", {frames_done, drop_count}, 0);
    areset = 1'b0;
    step();
    got_rd = got_n;
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
